// File: rtl/cnn_layer_accel_awe_rowbuffer_reader.sv
// rtl/cnn_layer_accel_awe_rowbuffer_reader.sv - read-side sequencer for the AWE row-buffer ring
// Waits for K resident rows, streams K-pixel columns through a 2-entry FIFO, releases rows as they retire.

module cnn_layer_accel_awe_rowbuffer_reader #(
  parameter int C_PIXEL_WIDTH = 16,
  parameter int C_BRAM_DEPTH  = 1024,
  parameter int C_KERNEL      = 3,
  parameter int C_NUM_BUF     = 4,
  localparam int AW = $clog2(C_BRAM_DEPTH),
  localparam int PW = C_PIXEL_WIDTH,
  localparam int BW = $clog2(C_NUM_BUF)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [AW-1:0]             numRows,
  input  logic [AW-1:0]             numCols,
  input  logic [AW:0]               wr_rows_done,
  output logic                      rd_en,
  output logic [AW-1:0]             rd_addr,
  input  logic [C_NUM_BUF*PW-1:0]   rd_data,
  output logic [C_KERNEL*PW-1:0]    pixel_dataout,
  output logic                      pixel_dataout_valid,
  input  logic                      pixel_dataout_ready,
  output logic [AW-1:0]             out_row,
  output logic [AW-1:0]             out_col,
  output logic                      row_release,
  output logic                      busy,
  output logic                      done
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT_ROWS, S_READ, S_ROW_END, S_DONE} state_t;

  state_t                 state, state_n;
  logic [AW-1:0]          rows_q, cols_q, rd_row, rd_col;
  logic [BW-1:0]          rd_buf;
  logic                   inflight;
  logic [BW-1:0]          lane_idx   [C_KERNEL];
  logic [BW-1:0]          lane_idx_q [C_KERNEL];
  logic [AW-1:0]          tag_row_q, tag_col_q;
  logic [C_KERNEL*PW-1:0] fifo_data [2];
  logic [AW-1:0]          fifo_row  [2];
  logic [AW-1:0]          fifo_col  [2];
  logic                   wp, rp;
  logic [1:0]             cnt;
  logic                   done_q;
  logic                   pop, rd_go, release_go, start_go, last_col;
  logic [2:0]             occ_after;
  logic [C_KERNEL*PW-1:0] ret_word;

  // A pop in the same cycle frees a slot, which keeps the pipe at one beat per cycle.
  assign pop       = (cnt != 2'd0) && pixel_dataout_ready;
  assign occ_after = {1'b0, cnt} + {2'b00, inflight} - {2'b00, pop};
  assign last_col  = (rd_col == cols_q - AW'(1));

  always_comb begin
    for (int i = 0; i < C_KERNEL; i++) begin
      if (int'(rd_buf) + i >= C_NUM_BUF) lane_idx[i] = BW'(int'(rd_buf) + i - C_NUM_BUF);
      else                               lane_idx[i] = BW'(int'(rd_buf) + i);
    end
  end

  always_comb begin
    ret_word = '0;
    for (int i = 0; i < C_KERNEL; i++)
      ret_word[i*PW +: PW] = rd_data[int'(lane_idx_q[i])*PW +: PW];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n    = state;
    rd_go      = 1'b0;
    release_go = 1'b0;
    start_go   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          start_go = 1'b1;
          if (numRows < AW'(C_KERNEL) || numCols == '0) state_n = S_DONE;
          else                                          state_n = S_WAIT_ROWS;
        end
      end
      S_WAIT_ROWS: begin
        if (wr_rows_done >= {1'b0, rd_row} + (AW+1)'(C_KERNEL)) state_n = S_READ;
      end
      S_READ: begin
        if (occ_after < 3'd2) begin
          rd_go = 1'b1;
          if (last_col) state_n = S_ROW_END;
        end
      end
      S_ROW_END: begin
        if (cnt == 2'd0 && !inflight) begin
          release_go = 1'b1;
          state_n    = (rd_row == rows_q - AW'(C_KERNEL)) ? S_DONE : S_WAIT_ROWS;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rows_q    <= '0;
      cols_q    <= '0;
      rd_row    <= '0;
      rd_col    <= '0;
      rd_buf    <= '0;
      inflight  <= 1'b0;
      tag_row_q <= '0;
      tag_col_q <= '0;
      done_q    <= 1'b0;
      for (int i = 0; i < C_KERNEL; i++) lane_idx_q[i] <= '0;
    end else begin
      inflight <= rd_go;
      done_q   <= (state == S_DONE);
      if (start_go) begin
        rows_q <= numRows;
        cols_q <= numCols;
        rd_row <= '0;
        rd_col <= '0;
        rd_buf <= '0;
      end
      if (rd_go) begin
        rd_col    <= last_col ? '0 : rd_col + AW'(1);
        tag_row_q <= rd_row;
        tag_col_q <= rd_col;
        for (int i = 0; i < C_KERNEL; i++) lane_idx_q[i] <= lane_idx[i];
      end
      if (release_go) begin
        rd_row <= rd_row + AW'(1);
        rd_buf <= (rd_buf == BW'(C_NUM_BUF - 1)) ? '0 : rd_buf + BW'(1);
      end
    end
  end

  // Output FIFO: the returning word is captured the cycle after its read strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp  <= 1'b0;
      rp  <= 1'b0;
      cnt <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
        fifo_row[i]  <= '0;
        fifo_col[i]  <= '0;
      end
    end else begin
      if (inflight) begin
        fifo_data[wp] <= ret_word;
        fifo_row[wp]  <= tag_row_q;
        fifo_col[wp]  <= tag_col_q;
        wp            <= ~wp;
      end
      if (pop) rp <= ~rp;
      cnt <= cnt + {1'b0, inflight} - {1'b0, pop};
    end
  end

  assign rd_en               = rd_go;
  assign rd_addr             = rd_col;
  assign pixel_dataout       = fifo_data[rp];
  assign pixel_dataout_valid = (cnt != 2'd0);
  assign out_row             = pixel_dataout_valid ? fifo_row[rp] : rd_row;
  assign out_col             = pixel_dataout_valid ? fifo_col[rp] : rd_col;
  assign row_release         = release_go;
  assign busy                = (state != S_IDLE);
  assign done                = done_q;

endmodule

// File: tb/tb_cnn_layer_accel_awe_rowbuffer_reader.sv
// tb/tb_cnn_layer_accel_awe_rowbuffer_reader.sv - bench for the AWE row-buffer reader
// Models the writer ring and buffer contents; compares every accepted beat against image arithmetic.

module tb_cnn_layer_accel_awe_rowbuffer_reader;
  localparam int PW = 16, AW = 10, K = 3, NB = 4, MAXR = 16, MAXC = 16;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                start = 1'b0;
  logic [AW-1:0]       numRows = '0, numCols = '0;
  logic [AW:0]         wr_rows_done = '0;
  logic                rd_en;
  logic [AW-1:0]       rd_addr;
  logic [NB*PW-1:0]    rd_data = '0;
  logic [K*PW-1:0]     pixel_dataout;
  logic                pixel_dataout_valid;
  logic                pixel_dataout_ready = 1'b0;
  logic [AW-1:0]       out_row, out_col;
  logic                row_release, busy, done;

  cnn_layer_accel_awe_rowbuffer_reader dut (
    .clk(clk), .rst(rst), .start(start), .numRows(numRows), .numCols(numCols),
    .wr_rows_done(wr_rows_done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .pixel_dataout(pixel_dataout), .pixel_dataout_valid(pixel_dataout_valid),
    .pixel_dataout_ready(pixel_dataout_ready), .out_row(out_row), .out_col(out_col),
    .row_release(row_release), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct { int row; int col; logic [K*PW-1:0] data; } beat_t;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  logic [PW-1:0] img [MAXR][MAXC];
  int buf_row [NB] = '{-1, -1, -1, -1};
  int f_rows = 0, f_cols = 0, wr = 0, rel_cnt = 0, wr_period = 0, wr_timer = 0, ready_pct = 0;
  logic [NB*PW-1:0] next_rd_data = '0;
  beat_t beats [$];
  beat_t exp_q [$];
  int issued = 0, done_cnt = 0, first_rd_cyc = -1, first_vld_cyc = -1, start_cyc = 0, done_cyc = -1, wr3_cyc = -1;
  int early_viol = 0, addr_viol = 0, stab_viol = 0, occ_viol = 0, run = 0, max_run = 0;
  logic prev_hold = 1'b0;
  logic [K*PW-1:0] prev_data = '0;
  logic [AW-1:0] prev_row = '0, prev_col = '0;

  // Environment: read-data return, consumer ready and a writer bounded by the ring's free buffers.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      rd_data = next_rd_data;
      pixel_dataout_ready = ($urandom_range(99) < ready_pct);
      wr_timer++;
      if (wr < f_rows && wr < rel_cnt + NB && (wr_period == 0 || wr_timer >= wr_period)) begin
        buf_row[wr % NB] = wr;
        wr++;
        wr_timer = 0;
        if (wr == K) wr3_cyc = cyc;
      end
      wr_rows_done = (AW+1)'(wr);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) prev_hold = 1'b0;
      else begin
        if (rd_en) begin
          if (issued == 0) first_rd_cyc = cyc;
          if (f_cols > 0 && int'(wr_rows_done) < issued / f_cols + K) early_viol++;
          if (f_cols > 0 && int'(rd_addr) != issued % f_cols) addr_viol++;
          for (int b = 0; b < NB; b++)
            next_rd_data[b*PW +: PW] = (buf_row[b] >= 0 && rd_addr < MAXC) ? img[buf_row[b]][rd_addr] : '0;
          issued++;
        end
        if (prev_hold && (!pixel_dataout_valid || pixel_dataout !== prev_data ||
                          out_row !== prev_row || out_col !== prev_col)) stab_viol++;
        if (pixel_dataout_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
        if (pixel_dataout_valid && pixel_dataout_ready) begin
          beat_t b;
          b.row = int'(out_row); b.col = int'(out_col); b.data = pixel_dataout;
          beats.push_back(b);
          run++;
          if (run > max_run) max_run = run;
        end else run = 0;
        prev_hold = pixel_dataout_valid && !pixel_dataout_ready;
        prev_data = pixel_dataout; prev_row = out_row; prev_col = out_col;
        if (issued - beats.size() > 2) occ_viol++;
        if (row_release) rel_cnt++;
        if (done) begin done_cnt++; done_cyc = cyc; end
      end
    end
  end

  function automatic void build_expected();
    exp_q.delete();
    if (f_rows >= K && f_cols > 0)
      for (int r = 0; r <= f_rows - K; r++)
        for (int c = 0; c < f_cols; c++) begin
          beat_t b;
          b.row = r; b.col = c;
          for (int i = 0; i < K; i++) b.data[i*PW +: PW] = img[r+i][c];
          exp_q.push_back(b);
        end
  endfunction

  task automatic setup_frame(input int rows, input int cols, input int period, input int pct, input bit prefill);
    @(negedge clk); #2;
    f_rows = rows; f_cols = cols; wr_period = period; wr_timer = 0; ready_pct = pct;
    rel_cnt = 0; issued = 0; done_cnt = 0; first_rd_cyc = -1; first_vld_cyc = -1; done_cyc = -1; wr3_cyc = -1;
    early_viol = 0; addr_viol = 0; stab_viol = 0; occ_viol = 0; run = 0; max_run = 0; prev_hold = 1'b0;
    beats.delete();
    for (int r = 0; r < MAXR; r++) for (int c = 0; c < MAXC; c++) img[r][c] = PW'($urandom);
    for (int b = 0; b < NB; b++) buf_row[b] = -1;
    wr = 0;
    if (prefill) while (wr < rows && wr < NB) begin buf_row[wr % NB] = wr; wr++; end
    if (wr >= K) wr3_cyc = cyc;
    wr_rows_done = (AW+1)'(wr);
    numRows = AW'(rows); numCols = AW'(cols);
    start = 1'b1; start_cyc = cyc;
    @(negedge clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge clk); #3;
      if (done_cnt > 0) ok = 1'b1;
    end
    repeat (4) @(negedge clk);
    #3;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({rd_en, rd_addr, pixel_dataout, pixel_dataout_valid, out_row, out_col, row_release, busy, done} !== '0) begin
      n_bad++; $display("FAIL reset_outputs: got valid=%b busy=%b rd_en=%b want all zero", pixel_dataout_valid, busy, rd_en);
    end
    #2 rst = 1'b1;
  endtask

  task automatic test_prewritten();
    bit ok;
    setup_frame(10, 10, 0, 100, 1'b1);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL pre_busy: got %b want 1", busy); end
    wait_done(3000, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL pre_done_timeout: got none want done"); end
    build_expected();
    n_cmp++; if (beats.size() != exp_q.size()) begin n_bad++; $display("FAIL pre_beat_count: got %0d want %0d", beats.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < beats.size()) begin
      n_cmp++;
      if (beats[i].row != exp_q[i].row || beats[i].col != exp_q[i].col || beats[i].data !== exp_q[i].data) begin
        n_bad++; $display("FAIL pre_beat%0d: got (%0d,%0d,%h) want (%0d,%0d,%h)", i, beats[i].row, beats[i].col, beats[i].data, exp_q[i].row, exp_q[i].col, exp_q[i].data);
      end
    end
    n_cmp++; if (rel_cnt != 8) begin n_bad++; $display("FAIL pre_releases: got %0d want 8", rel_cnt); end
    n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL pre_done_count: got %0d want 1", done_cnt); end
    n_cmp++; if (first_vld_cyc - first_rd_cyc != 2) begin n_bad++; $display("FAIL pre_latency: got %0d want 2", first_vld_cyc - first_rd_cyc); end
    n_cmp++; if (max_run < 10) begin n_bad++; $display("FAIL pre_throughput: got run %0d want 10", max_run); end
    n_cmp++; if (addr_viol != 0 || occ_viol != 0) begin n_bad++; $display("FAIL pre_addr_occ: got %0d/%0d want 0/0", addr_viol, occ_viol); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL pre_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_stepped_writer();
    bit ok;
    setup_frame(10, 10, 30, 100, 1'b0);
    wait_done(5000, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL step_done_timeout: got none want done"); end
    n_cmp++; if (wr3_cyc < 0 || first_rd_cyc <= wr3_cyc) begin n_bad++; $display("FAIL step_first_read: got cycle %0d want > %0d", first_rd_cyc, wr3_cyc); end
    n_cmp++; if (early_viol != 0) begin n_bad++; $display("FAIL step_early_reads: got %0d want 0", early_viol); end
    build_expected();
    n_cmp++; if (beats.size() != exp_q.size()) begin n_bad++; $display("FAIL step_beat_count: got %0d want %0d", beats.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < beats.size()) begin
      n_cmp++;
      if (beats[i].row != exp_q[i].row || beats[i].col != exp_q[i].col || beats[i].data !== exp_q[i].data) begin
        n_bad++; $display("FAIL step_beat%0d: got (%0d,%0d,%h) want (%0d,%0d,%h)", i, beats[i].row, beats[i].col, beats[i].data, exp_q[i].row, exp_q[i].col, exp_q[i].data);
      end
    end
    n_cmp++; if (rel_cnt != 8) begin n_bad++; $display("FAIL step_releases: got %0d want 8", rel_cnt); end
  endtask

  task automatic test_random_ready();
    bit ok;
    setup_frame(8, 12, 0, 50, 1'b1);
    repeat (20) @(negedge clk);
    #2 numRows = AW'(3); numCols = AW'(5); start = 1'b1;
    @(negedge clk); #2 start = 1'b0;
    wait_done(5000, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL rnd_done_timeout: got none want done"); end
    build_expected();
    n_cmp++; if (beats.size() != exp_q.size()) begin n_bad++; $display("FAIL rnd_beat_count: got %0d want %0d", beats.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < beats.size()) begin
      n_cmp++;
      if (beats[i].row != exp_q[i].row || beats[i].col != exp_q[i].col || beats[i].data !== exp_q[i].data) begin
        n_bad++; $display("FAIL rnd_beat%0d: got (%0d,%0d,%h) want (%0d,%0d,%h)", i, beats[i].row, beats[i].col, beats[i].data, exp_q[i].row, exp_q[i].col, exp_q[i].data);
      end
    end
    n_cmp++; if (stab_viol != 0) begin n_bad++; $display("FAIL rnd_stable: got %0d changes want 0", stab_viol); end
    n_cmp++; if (occ_viol != 0) begin n_bad++; $display("FAIL rnd_occupancy: got %0d want 0", occ_viol); end
    n_cmp++; if (rel_cnt != 6 || done_cnt != 1) begin n_bad++; $display("FAIL rnd_rel_done: got %0d/%0d want 6/1", rel_cnt, done_cnt); end
  endtask

  task automatic test_ring_wrap();
    bit ok;
    setup_frame(9, 7, 3, 70, 1'b0);
    wait_done(5000, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL wrap_done_timeout: got none want done"); end
    build_expected();
    n_cmp++; if (beats.size() != exp_q.size()) begin n_bad++; $display("FAIL wrap_beat_count: got %0d want %0d", beats.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < beats.size()) begin
      n_cmp++;
      if (beats[i].row != exp_q[i].row || beats[i].col != exp_q[i].col || beats[i].data !== exp_q[i].data) begin
        n_bad++; $display("FAIL wrap_beat%0d: got (%0d,%0d,%h) want (%0d,%0d,%h)", i, beats[i].row, beats[i].col, beats[i].data, exp_q[i].row, exp_q[i].col, exp_q[i].data);
      end
    end
    n_cmp++; if (rel_cnt != 7 || early_viol != 0) begin n_bad++; $display("FAIL wrap_rel_early: got %0d/%0d want 7/0", rel_cnt, early_viol); end
  endtask

  task automatic test_short_frames();
    bit ok;
    setup_frame(2, 5, 0, 100, 1'b1);
    wait_done(50, ok);
    n_cmp++; if (!ok || done_cyc - start_cyc != 2) begin n_bad++; $display("FAIL short_done_latency: got %0d want 2", done_cyc - start_cyc); end
    n_cmp++; if (beats.size() != 0 || rel_cnt != 0 || issued != 0) begin n_bad++; $display("FAIL short_activity: got %0d beats %0d rel want 0 0", beats.size(), rel_cnt); end
    setup_frame(5, 0, 0, 100, 1'b1);
    wait_done(50, ok);
    n_cmp++; if (!ok || beats.size() != 0 || rel_cnt != 0) begin n_bad++; $display("FAIL zero_cols: got ok=%0d beats=%0d want 1 0", ok, beats.size()); end
    setup_frame(6, 1, 0, 100, 1'b1);
    wait_done(500, ok);
    build_expected();
    n_cmp++; if (!ok || beats.size() != exp_q.size()) begin n_bad++; $display("FAIL onecol_count: got %0d want %0d", beats.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < beats.size()) begin
      n_cmp++;
      if (beats[i].row != exp_q[i].row || beats[i].col != exp_q[i].col || beats[i].data !== exp_q[i].data) begin
        n_bad++; $display("FAIL onecol_beat%0d: got (%0d,%0d,%h) want (%0d,%0d,%h)", i, beats[i].row, beats[i].col, beats[i].data, exp_q[i].row, exp_q[i].col, exp_q[i].data);
      end
    end
    n_cmp++; if (rel_cnt != 4) begin n_bad++; $display("FAIL onecol_releases: got %0d want 4", rel_cnt); end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    int n;
    setup_frame(10, 10, 0, 100, 1'b1);
    n = 0;
    while (beats.size() < 15 && n < 1000) begin @(negedge clk); n++; end
    n_cmp++; if (beats.size() < 15) begin n_bad++; $display("FAIL midrst_progress: got %0d beats want 15", beats.size()); end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({rd_en, rd_addr, pixel_dataout, pixel_dataout_valid, out_row, out_col, row_release, busy, done} !== '0) begin
      n_bad++; $display("FAIL midrst_outputs: got valid=%b busy=%b row=%0d col=%0d want all zero", pixel_dataout_valid, busy, out_row, out_col);
    end
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (done_cnt != 0 || busy !== 1'b0) begin n_bad++; $display("FAIL midrst_abort: got done=%0d busy=%b want 0 0", done_cnt, busy); end
    setup_frame(10, 10, 0, 60, 1'b1);
    wait_done(5000, ok);
    build_expected();
    n_cmp++; if (!ok || beats.size() != exp_q.size()) begin n_bad++; $display("FAIL midrst_count: got %0d want %0d", beats.size(), exp_q.size()); end
    n_cmp++; if (beats.size() == 0 || beats[0].row != 0 || beats[0].col != 0) begin n_bad++; $display("FAIL midrst_first_beat: got (%0d,%0d) want (0,0)", beats.size() ? beats[0].row : -1, beats.size() ? beats[0].col : -1); end
    foreach (exp_q[i]) if (i < beats.size()) begin
      n_cmp++;
      if (beats[i].row != exp_q[i].row || beats[i].col != exp_q[i].col || beats[i].data !== exp_q[i].data) begin
        n_bad++; $display("FAIL midrst_beat%0d: got (%0d,%0d,%h) want (%0d,%0d,%h)", i, beats[i].row, beats[i].col, beats[i].data, exp_q[i].row, exp_q[i].col, exp_q[i].data);
      end
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_prewritten();
    test_stepped_writer();
    test_random_ready();
    test_ring_wrap();
    test_short_frames();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
